// File: rtl/mips_fetch_queue.sv
// mips_fetch_queue: instruction-fetch front end feeding the IF/ID latch.
// Issues sequential PC fetches to instruction memory under a credit limit,
// buffers in-order responses in a small queue, absorbs ID stalls and
// flushes on redirects (stale in-flight responses are counted and dropped).
// Optional build macro MIPS_FETCH_QUEUE_BYPASS_EN: forwards a response
// straight to out_* when the queue is empty (zero-cycle fetch latency).
module mips_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0020
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_ir,
    output logic [31:0] out_pc4,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    logic [31:0]   pc;
    logic          run;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [AW-1:0] head, tail;
    logic [AW-1:0] pf_wr, pf_rd;

    logic [31:0] q_ir  [DEPTH];
    logic [31:0] q_pc4 [DEPTH];
    logic [31:0] pf_pc [DEPTH];

    logic        req_fire;
    logic        resp_ok;
    logic        resp_keep;
    logic        push;
    logic        pop_q;
    logic [31:0] resp_pc4;
    logic [CW:0] credit_used;

    // Credit covers both buffered words and in-flight requests so a
    // response always has a queue slot waiting for it.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    // run holds requests off while reset is asserted and for the first edge after.
    assign imem_req_valid = run && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response on the redirect cycle belongs to the old path and is dropped.
    assign resp_ok   = imem_resp_valid && (outstanding != '0);
    assign resp_keep = resp_ok && (drop_cnt == '0) && !redirect_valid;
    assign resp_pc4  = pf_pc[pf_rd] + 32'd4;
    assign pop_q     = (count != '0) && !stall && !redirect_valid;

`ifdef MIPS_FETCH_QUEUE_BYPASS_EN
    // An empty queue with no stall consumes the forwarded word directly.
    assign push = resp_keep && !((count == '0) && !stall);
`else
    assign push = resp_keep;
`endif

    // Head presentation; an empty queue shows a bubble.
    always_comb begin
        out_valid = 1'b0;
        out_ir    = NOP_WORD;
        out_pc4   = '0;
        if (count != '0) begin
            out_valid = 1'b1;
            out_ir    = q_ir[head];
            out_pc4   = q_pc4[head];
        end
`ifdef MIPS_FETCH_QUEUE_BYPASS_EN
        else if (resp_keep) begin
            out_valid = 1'b1;
            out_ir    = imem_resp_data;
            out_pc4   = resp_pc4;
        end
`endif
    end

    // PC, credit counters, pointers and the sticky error flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            run         <= 1'b0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            head        <= '0;
            tail        <= '0;
            pf_wr       <= '0;
            pf_rd       <= '0;
            resp_err    <= 1'b0;
        end else begin
            run         <= 1'b1;
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_ok);
            if (req_fire)
                pf_wr <= pf_wr + AW'(1);
            if (resp_ok)
                pf_rd <= pf_rd + AW'(1);
            if (imem_resp_valid && (outstanding == '0))
                resp_err <= 1'b1;

            if (redirect_valid) begin
                pc       <= redirect_pc;
                count    <= '0;
                head     <= '0;
                tail     <= '0;
                drop_cnt <= outstanding - CW'(resp_ok);
            end else begin
                if (req_fire)
                    pc <= pc + 32'd4;
                if (resp_ok && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - CW'(1);
                if (push)
                    tail <= tail + AW'(1);
                if (pop_q)
                    head <= head + AW'(1);
                if (push && !pop_q)
                    count <= count + CW'(1);
                else if (!push && pop_q)
                    count <= count - CW'(1);
            end
        end
    end

    // Storage arrays carry no reset; validity comes from the counters.
    always_ff @(posedge clock) begin
        if (req_fire)
            pf_pc[pf_wr] <= pc;
        if (push) begin
            q_ir[tail]  <= imem_resp_data;
            q_pc4[tail] <= resp_pc4;
        end
    end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: phase table of stimulus with end-of-phase
// expectations, an in-order memory model, and an output scoreboard.
module tb_mips_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0020;
`ifdef MIPS_FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_ir;
    logic [31:0] out_pc4;
    logic        resp_err;

    mips_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
        .clock(clock), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ir(out_ir), .out_pc4(out_pc4),
        .resp_err(resp_err)
    );

    always #5 clock = ~clock;

    typedef struct { logic [31:0] addr; int ep; int due; } mem_t;
    typedef struct { logic [31:0] ir; logic [31:0] pc4; } exp_t;
    typedef struct {
        int n; bit st; bit rdy; int lat; bit rv; logic [31:0] rpc;
        int exp_ov; int exp_rqv;
    } phase_t;

    mem_t        mem_q[$];
    exp_t        exp_q[$];
    logic [31:0] exp_pc = RESET_PC;
    int          epoch = 0;
    int          cyc = 0;
    bit          err_exp = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
        else
            n_pass++;
    endtask

    // One clock cycle: drive at posedge+1, sample at posedge+5, advance.
    task automatic step(input bit st, input bit rdy, input int lat, input bit rv,
                        input logic [31:0] rpc, input bit frc,
                        output bit ov, output bit rqv);
        int   cnt0, out0;
        bit   got, pushed, exp_ov;
        mem_t m;
        exp_t e;
        cnt0 = exp_q.size();
        out0 = mem_q.size();
        stall = st; imem_req_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        got = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_resp_valid = got || frc;
        imem_resp_data  = got ? mem_q[0].addr : 32'hDEAD_BEEF;
        #4;
        ov  = out_valid;
        rqv = imem_req_valid;
        chk("credit", rqv, 32'(!rv && (cnt0 + out0 < DEPTH)));
        chk("pc", imem_addr, exp_pc);
        chk("resp_err", resp_err, 32'(err_exp));
        pushed = 1'b0;
        if (got) begin
            m = mem_q.pop_front();
            if (!rv && m.ep == epoch) begin
                e.ir = m.addr; e.pc4 = m.addr + 32'd4;
                exp_q.push_back(e);
                pushed = 1'b1;
            end
        end
        exp_ov = (cnt0 > 0) || (BYP && pushed);
        chk("out_valid", ov, 32'(exp_ov));
        if (exp_ov) begin
            chk("out_ir", out_ir, exp_q[0].ir);
            chk("out_pc4", out_pc4, exp_q[0].pc4);
        end else begin
            chk("bubble_ir", out_ir, NOP_WORD);
            chk("bubble_pc4", out_pc4, 32'h0);
        end
        if (rv) begin
            exp_q.delete();
            epoch++;
            exp_pc = rpc;
        end else begin
            if (exp_ov && !st)
                void'(exp_q.pop_front());
            if (rqv && rdy) begin
                m.addr = imem_addr; m.ep = epoch; m.due = cyc + lat;
                mem_q.push_back(m);
                exp_pc = exp_pc + 32'd4;
            end
        end
        if (frc && out0 == 0)
            err_exp = 1'b1;
        @(posedge clock);
        #1;
        cyc++;
    endtask

    phase_t phases[13];
    bit ov, rqv;

    initial begin
        //            n   st rdy lat rv  rpc            ov  rqv
        phases[0]  = '{12, 0, 1, 1, 0, 32'h0,          1,  1};
        phases[1]  = '{10, 1, 1, 1, 0, 32'h0,          1,  0};
        phases[2]  = '{10, 0, 1, 1, 0, 32'h0,          1, -1};
        phases[3]  = '{ 6, 0, 1, 3, 0, 32'h0,         -1, -1};
        phases[4]  = '{ 1, 0, 1, 3, 1, 32'h100,       -1,  0};
        phases[5]  = '{ 1, 0, 1, 3, 0, 32'h0,          0, -1};
        phases[6]  = '{14, 0, 1, 3, 0, 32'h0,         -1, -1};
        phases[7]  = '{ 6, 0, 1, 1, 0, 32'h0,         -1, -1};
        phases[8]  = '{ 1, 0, 1, 1, 1, 32'h200,       -1,  0};
        phases[9]  = '{ 1, 0, 1, 1, 0, 32'h0,          0,  1};
        phases[10] = '{ 1, 0, 1, 1, 1, 32'hFFFF_FFF8, -1,  0};
        phases[11] = '{10, 0, 1, 1, 0, 32'h0,          1,  1};
        phases[12] = '{ 6, 1, 0, 1, 0, 32'h0,          1, -1};

        #3;
        chk("rst_out_valid", out_valid, 32'h0);
        chk("rst_out_ir", out_ir, NOP_WORD);
        chk("rst_out_pc4", out_pc4, 32'h0);
        chk("rst_req_valid", imem_req_valid, 32'h0);
        chk("rst_resp_err", resp_err, 32'h0);
        chk("rst_addr", imem_addr, RESET_PC);
        @(posedge clock);
        @(posedge clock);
        #5 reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 13; i++) begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < phases[i].n; k++) begin
                step(phases[i].st, phases[i].rdy, phases[i].lat, phases[i].rv,
                     phases[i].rpc, 1'b0, ov, rqv);
                if (i == 0 && seen)
                    chk("no_bubble_after_start", ov, 32'h1);
                if (ov) seen = 1'b1;
            end
            if (phases[i].exp_ov >= 0)
                chk($sformatf("phase%0d_out_valid", i), ov, 32'(phases[i].exp_ov));
            if (phases[i].exp_rqv >= 0)
                chk($sformatf("phase%0d_req_valid", i), rqv, 32'(phases[i].exp_rqv));
        end

        // Orphan response while stalled with words buffered and nothing in flight.
        step(1, 0, 1, 0, 32'h0, 1'b1, ov, rqv);
        for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 32'h0, 1'b0, ov, rqv);
        chk("resp_err_sticky", resp_err, 32'h1);
        for (int k = 0; k < 8; k++) step(0, 1, 1, 0, 32'h0, 1'b0, ov, rqv);

        // Asynchronous reset in the middle of a latency-2 stream.
        for (int k = 0; k < 5; k++) step(0, 1, 2, 0, 32'h0, 1'b0, ov, rqv);
        stall = 1'b0; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; redirect_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_out_valid", out_valid, 32'h0);
        chk("async_rst_out_ir", out_ir, NOP_WORD);
        chk("async_rst_out_pc4", out_pc4, 32'h0);
        chk("async_rst_req_valid", imem_req_valid, 32'h0);
        chk("async_rst_resp_err", resp_err, 32'h0);
        chk("async_rst_addr", imem_addr, RESET_PC);
        mem_q.delete();
        exp_q.delete();
        exp_pc = RESET_PC;
        err_exp = 1'b0;
        epoch++;
        @(posedge clock);
        @(posedge clock);
        #5 reset_n = 1'b1;
        @(posedge clock);
        #1;
        cyc++;
        for (int k = 0; k < 10; k++) step(0, 1, 1, 0, 32'h0, 1'b0, ov, rqv);
        chk("post_reset_stream_valid", ov, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
